// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared definitions for the OTTER pipeline control slice.
//   opcode_t      : RV32I major opcodes seen by decode
//   hz_state_t    : hazard sequencer states (RUN, SQUASH, HOLD)
//   PC_SEL_*      : execute-stage PC source select encodings
// -----------------------------------------------------------------------------
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  // Encodings are fixed so the debug state output is stable across builds.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } hz_state_t;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_JALR   = 2'd1;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd2;
  localparam logic [1:0] PC_SEL_JAL    = 2'd3;

endpackage

// File: rtl/otter_sat_counter.sv
// -----------------------------------------------------------------------------
// otter_sat_counter
// Saturating up-counter with synchronous clear. Clear wins over increment.
//   clk : clock
//   clr : synchronous clear to zero
//   inc : increment by one, holding at all-ones
//   q   : count value
// -----------------------------------------------------------------------------
module otter_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = 1;

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// otter_hazard_ctrl
// Central stall/squash sequencer for the 5-stage OTTER pipeline.
//   CLK, RESET              : clock, synchronous active-high reset
//   de_rs1/rs2_addr/_used   : decode-stage source registers and use flags
//   ex_rd_addr, ex_mem_read : execute-stage destination and load flag
//   ex_pc_sel               : execute redirect select (nonzero = taken)
//   mem_stall               : data memory not ready, freeze everything
//   clr_cnt                 : synchronous clear of performance counters
//   pc_write, fetch_rd      : PC load and IMEM read enables
//   if_de_en .. mem_wb_en   : pipeline register enables
//   if_flush, de_flush      : NOP / bubble injection into IF/DE, DE/EX
//   state_o                 : current FSM state (debug)
//   cnt_lu/redir/mstall     : saturating hazard counters
// Every control output is combinational from state and inputs and applies
// to the clock edge that closes the current cycle: an enable of 1 means the
// register captures at that edge, a flush of 1 means it captures a bubble.
// -----------------------------------------------------------------------------
module otter_hazard_ctrl
  import otter_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int REDIR_SQUASH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       de_rs1_addr,
  input  logic [4:0]       de_rs2_addr,
  input  logic             de_rs1_used,
  input  logic             de_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic [1:0]       ex_pc_sel,
  input  logic             mem_stall,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             fetch_rd,
  output logic             if_de_en,
  output logic             if_flush,
  output logic             de_ex_en,
  output logic             de_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_redir,
  output logic [CNT_W-1:0] cnt_mstall
);

  localparam logic [1:0] SQ_RELOAD = (REDIR_SQUASH > 0) ? 2'(REDIR_SQUASH - 1) : 2'd0;
  localparam hz_state_t  REDIR_NEXT = (REDIR_SQUASH > 0) ? SQUASH : RUN;

  hz_state_t  state, ret_state, eff_state;
  logic [1:0] sq_cnt, ret_sq, eff_sq;
  logic       load_use, redirect;
  logic       inc_lu, inc_redir, inc_mstall;

  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((de_rs1_used && (de_rs1_addr == ex_rd_addr)) ||
                     (de_rs2_used && (de_rs2_addr == ex_rd_addr)));
  assign redirect = (ex_pc_sel != PC_SEL_SEQ);
  assign state_o  = state;

  always_comb begin
    // Leaving HOLD resumes the saved state's rules in the same cycle.
    eff_state = state;
    eff_sq    = sq_cnt;
    if (state == HOLD) begin
      eff_state = ret_state;
      eff_sq    = ret_sq;
    end

    pc_write   = 1'b1;
    fetch_rd   = 1'b1;
    if_de_en   = 1'b1;
    if_flush   = 1'b0;
    de_ex_en   = 1'b1;
    de_flush   = 1'b0;
    ex_mem_en  = 1'b1;
    mem_wb_en  = 1'b1;
    inc_lu     = 1'b0;
    inc_redir  = 1'b0;
    inc_mstall = 1'b0;

    if (RESET) begin
      // free-running pipeline, no flushes, no counting
    end else if (mem_stall) begin
      pc_write   = 1'b0;
      fetch_rd   = 1'b0;
      if_de_en   = 1'b0;
      de_ex_en   = 1'b0;
      ex_mem_en  = 1'b0;
      mem_wb_en  = 1'b0;
      inc_mstall = 1'b1;
    end else if (redirect) begin
      // Also covers a redirect seen while squashing: counted and reloaded.
      if_flush  = 1'b1;
      de_flush  = 1'b1;
      inc_redir = 1'b1;
    end else if (eff_state == SQUASH) begin
      if_flush = 1'b1;
      de_flush = 1'b1;
    end else if (load_use) begin
      pc_write = 1'b0;
      fetch_rd = 1'b0;
      if_de_en = 1'b0;
      de_flush = 1'b1;
      inc_lu   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= RUN;
      sq_cnt    <= 2'd0;
      ret_state <= RUN;
      ret_sq    <= 2'd0;
    end else if (mem_stall) begin
      state <= HOLD;
      // Only capture on entry so a long stall keeps the original context.
      if (state != HOLD) begin
        ret_state <= state;
        ret_sq    <= sq_cnt;
      end
    end else if (redirect) begin
      state  <= REDIR_NEXT;
      sq_cnt <= SQ_RELOAD;
    end else if (eff_state == SQUASH) begin
      if (eff_sq == 2'd0) begin
        state  <= RUN;
        sq_cnt <= 2'd0;
      end else begin
        state  <= SQUASH;
        sq_cnt <= eff_sq - 2'd1;
      end
    end else begin
      state  <= RUN;
      sq_cnt <= 2'd0;
    end
  end

  otter_sat_counter #(.W(CNT_W)) u_cnt_lu (
    .clk (CLK), .clr (RESET | clr_cnt), .inc (inc_lu), .q (cnt_lu)
  );

  otter_sat_counter #(.W(CNT_W)) u_cnt_redir (
    .clk (CLK), .clr (RESET | clr_cnt), .inc (inc_redir), .q (cnt_redir)
  );

  otter_sat_counter #(.W(CNT_W)) u_cnt_mstall (
    .clk (CLK), .clr (RESET | clr_cnt), .inc (inc_mstall), .q (cnt_mstall)
  );

endmodule
